// File: rtl/fifo_frame_pkg.sv
// Shared types and helpers for the FIFO frame packer: FSM state encoding,
// default frame header and the payload checksum.
package fifo_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEAD = 3'd1,
        LEN  = 3'd2,
        BODY = 3'd3,
        CSUM = 3'd4
    } state_t;

    localparam int unsigned DEFAULT_HEADER = 32'h0000_00A5;

    // Checksum word is the two's complement of the running payload sum, so the
    // payload plus checksum adds up to zero. Callers truncate to their width.
    function automatic logic [31:0] frame_checksum(input logic [31:0] sum);
        return ~sum + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_frame_packer.sv
// Drains an async FIFO's read port and emits framed packets
// (header, length, payload, checksum) on a valid/ready stream.
module fifo_frame_packer
    import fifo_frame_pkg::*;
#(
    parameter int          DSIZE     = 8,
    parameter int          ASIZE     = 10,
    parameter int          FRAME_LEN = 16,
    parameter int          TIMEOUT   = 64,
    parameter int unsigned HEADER    = DEFAULT_HEADER
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             r_ok,
    input  logic [ASIZE-1:0] ruse,
    output logic             r_en,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sof,
    output logic             m_eof,
    output logic [15:0]      frame_cnt
);

    localparam int TW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [TW-1:0]    TIMER_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0]    TIMER_FIRE = TW'(TO_M1);
    localparam logic [ASIZE:0]   FULL_AVAIL = (ASIZE + 1)'(FRAME_LEN);
    localparam logic [DSIZE-1:0] FULL_LEN   = DSIZE'(FRAME_LEN);
    localparam logic [DSIZE-1:0] HEADER_W   = DSIZE'(HEADER);
    localparam logic [DSIZE-1:0] ONE_D      = DSIZE'(1);
    localparam logic [TW-1:0]    ONE_T      = TW'(1);

    state_t           state_reg, state_next;
    logic [DSIZE-1:0] len_reg, len_next;
    logic [DSIZE-1:0] remain_reg, remain_next;
    logic [DSIZE-1:0] csum_reg, csum_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [15:0]      frame_cnt_reg, frame_cnt_next;
    logic [ASIZE:0]   avail;

    // The word parked in the FIFO output stage is not included in ruse.
    assign avail     = {1'b0, ruse} + {{ASIZE{1'b0}}, r_ok};
    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            remain_reg    <= '0;
            csum_reg      <= '0;
            timer_reg     <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            remain_reg    <= remain_next;
            csum_reg      <= csum_next;
            timer_reg     <= timer_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        remain_next    = remain_reg;
        csum_next      = csum_reg;
        timer_next     = timer_reg;
        frame_cnt_next = frame_cnt_reg;
        r_en           = 1'b0;
        m_valid        = 1'b0;
        m_data         = '0;
        m_sof          = 1'b0;
        m_eof          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (avail == '0) begin
                    timer_next = '0;
                end else if (timer_reg != TIMER_MAX) begin
                    timer_next = timer_reg + ONE_T;
                end
                // A full frame wins over a pending timeout flush.
                if (avail >= FULL_AVAIL) begin
                    len_next   = FULL_LEN;
                    state_next = HEAD;
                end else if ((TIMEOUT != 0) && (avail != '0) && (timer_reg == TIMER_FIRE)) begin
                    len_next   = DSIZE'(avail);
                    state_next = HEAD;
                end
            end

            HEAD: begin
                m_valid = 1'b1;
                m_sof   = 1'b1;
                m_data  = HEADER_W;
                if (m_ready) begin
                    state_next = LEN;
                end
            end

            LEN: begin
                m_valid = 1'b1;
                m_data  = len_reg;
                if (m_ready) begin
                    remain_next = len_reg;
                    csum_next   = '0;
                    state_next  = BODY;
                end
            end

            BODY: begin
                // Straight pass-through; the FIFO holds rdata while r_en is low.
                m_data  = rdata;
                m_valid = r_ok;
                r_en    = m_ready;
                if (r_ok && m_ready) begin
                    csum_next   = csum_reg + rdata;
                    remain_next = remain_reg - ONE_D;
                    if (remain_reg == ONE_D) begin
                        state_next = CSUM;
                    end
                end
            end

            CSUM: begin
                m_valid = 1'b1;
                m_eof   = 1'b1;
                m_data  = DSIZE'(frame_checksum(32'(csum_reg)));
                if (m_ready) begin
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    timer_next     = '0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Directed bench for fifo_frame_packer: a queue-based FIFO drives the read port,
// a frame-level scoreboard checks every output transfer.
module tb_fifo_frame_packer;

    localparam int ASIZE = 10;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } word_t;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic rst_n;
    logic m_ready;

    // Instance A: default parameters
    logic [7:0]       a_mem[$];
    logic [7:0]       a_ostage;
    logic             a_ostage_v;
    logic [ASIZE-1:0] a_ruse;
    logic             a_r_en, a_m_valid, a_m_sof, a_m_eof;
    logic [7:0]       a_m_data;
    logic [15:0]      a_frame_cnt;

    // Instance B: timeout flushing disabled
    logic [7:0]       b_mem[$];
    logic [7:0]       b_ostage;
    logic             b_ostage_v;
    logic [ASIZE-1:0] b_ruse;
    logic             b_r_en, b_m_valid, b_m_sof, b_m_eof;
    logic [7:0]       b_m_data;
    logic [15:0]      b_frame_cnt;

    fifo_frame_packer #(.DSIZE(8), .ASIZE(ASIZE), .FRAME_LEN(16), .TIMEOUT(64)) u_a (
        .rclk(rclk), .rst_n(rst_n), .rdata(a_ostage), .r_ok(a_ostage_v), .ruse(a_ruse),
        .r_en(a_r_en), .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(m_ready),
        .m_sof(a_m_sof), .m_eof(a_m_eof), .frame_cnt(a_frame_cnt)
    );

    fifo_frame_packer #(.DSIZE(8), .ASIZE(ASIZE), .FRAME_LEN(16), .TIMEOUT(0)) u_b (
        .rclk(rclk), .rst_n(rst_n), .rdata(b_ostage), .r_ok(b_ostage_v), .ruse(b_ruse),
        .r_en(b_r_en), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(m_ready),
        .m_sof(b_m_sof), .m_eof(b_m_eof), .frame_cnt(b_frame_cnt)
    );

    // FIFO models: one-word output stage plus a backing queue counted by ruse.
    always @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem.delete();
            a_ostage   <= '0;
            a_ostage_v <= 1'b0;
            a_ruse     <= '0;
        end else begin
            if (!a_ostage_v || a_r_en) begin
                if (a_mem.size() > 0) begin
                    a_ostage   <= a_mem.pop_front();
                    a_ostage_v <= 1'b1;
                end else begin
                    a_ostage_v <= 1'b0;
                end
            end
            a_ruse <= ASIZE'(a_mem.size());
        end
    end

    always @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            b_mem.delete();
            b_ostage   <= '0;
            b_ostage_v <= 1'b0;
            b_ruse     <= '0;
        end else begin
            if (!b_ostage_v || b_r_en) begin
                if (b_mem.size() > 0) begin
                    b_ostage   <= b_mem.pop_front();
                    b_ostage_v <= 1'b1;
                end else begin
                    b_ostage_v <= 1'b0;
                end
            end
            b_ruse <= ASIZE'(b_mem.size());
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame model: header, length, payload, then the value that zeroes the sum.
    function automatic logic [7:0] build_frame(input logic [7:0] pl[$], output word_t fr[$]);
        int sum;
        logic [7:0] cs;
        sum = 0;
        fr = {};
        fr.push_back({8'hA5, 1'b1, 1'b0});
        fr.push_back({8'(pl.size()), 1'b0, 1'b0});
        foreach (pl[k]) begin
            fr.push_back({pl[k], 1'b0, 1'b0});
            sum += int'(pl[k]);
        end
        cs = 8'((256 - (sum % 256)) % 256);
        fr.push_back({cs, 1'b0, 1'b1});
        return cs;
    endfunction

    word_t exp_q[$];
    int    model_cnt = 0;
    int    xfers = 0;
    bit    prev_hold = 1'b0;
    word_t prev_word;

    // Scoreboard for instance A, sampled mid-low-phase after inputs settle.
    always begin
        word_t e;
        @(negedge rclk);
        #2;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
            prev_hold = 1'b0;
        end else begin
            check(a_frame_cnt == 16'(model_cnt), "frame_cnt", a_frame_cnt, model_cnt);
            if (prev_hold) begin
                check(a_m_valid, "hold_valid", a_m_valid, 1);
                check({a_m_data, a_m_sof, a_m_eof} == prev_word, "hold_word",
                      {a_m_data, a_m_sof, a_m_eof}, prev_word);
            end
            if (a_m_valid && m_ready) begin
                xfers++;
                $display("xfer %0d data=0x%02h sof=%0b eof=%0b", xfers, a_m_data, a_m_sof, a_m_eof);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", a_m_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({a_m_data, a_m_sof, a_m_eof} == e, "out_word",
                          {a_m_data, a_m_sof, a_m_eof}, e);
                    if (e.eof) model_cnt++;
                end
            end
            prev_hold = a_m_valid && !m_ready;
            prev_word = {a_m_data, a_m_sof, a_m_eof};
        end
    end

    task automatic enqueue(input word_t fr[$]);
        foreach (fr[k]) exp_q.push_back(fr[k]);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            @(negedge rclk);
            if (exp_q.size() == 0) break;
        end
        if (i == max_cycles) check(1'b0, name, exp_q.size(), 0);
        repeat (2) @(negedge rclk);
    endtask

    task automatic wait_xfers(input int target, input string name);
        int i;
        m_ready = 1'b1;
        for (i = 0; i < 500; i++) begin
            if (xfers >= target) break;
            @(negedge rclk);
        end
        if (i == 500) check(1'b0, name, xfers, target);
    endtask

    task automatic hold10(input string name);
        m_ready = 1'b0;
        repeat (10) begin
            @(negedge rclk);
            #1;
            check(a_r_en == 1'b0, {name, "_r_en"}, a_r_en, 0);
            check(a_m_valid == 1'b1, {name, "_valid"}, a_m_valid, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t      fr[$];
        word_t      got[$];
        logic [7:0] pl[$];
        logic [7:0] cs;
        int         n;
        int         base;
        int         vcnt;

        rst_n   = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge rclk);
        #1;
        check(a_r_en == 1'b0,    "rst_r_en",    a_r_en, 0);
        check(a_m_valid == 1'b0, "rst_valid",   a_m_valid, 0);
        check(a_m_sof == 1'b0,   "rst_sof",     a_m_sof, 0);
        check(a_m_eof == 1'b0,   "rst_eof",     a_m_eof, 0);
        check(a_m_data == 8'h00, "rst_data",    a_m_data, 0);
        check(a_frame_cnt == 0,  "rst_frame_cnt", a_frame_cnt, 0);
        @(negedge rclk);
        rst_n = 1'b1;

        // 1: full frame of 0x00..0x0F, header one cycle after avail reaches 16
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(i));
        cs = build_frame(pl, fr);
        check(cs == 8'h88, "t1_model_csum", cs, 8'h88);
        enqueue(fr);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge rclk);
            a_mem.push_back(8'(i));
        end
        for (n = 0; n < 10; n++) begin
            @(negedge rclk);
            #1;
            if (int'(a_ruse) + int'(a_ostage_v) >= 16) break;
        end
        check(n < 10, "t1_avail16", n, 0);
        check(a_m_valid == 1'b0, "t1_pre_header_valid", a_m_valid, 0);
        @(negedge rclk);
        #1;
        check(a_m_valid && a_m_sof, "t1_header_latency", {a_m_valid, a_m_sof}, 2'b11);
        wait_drain(100, "t1_drain");
        check(a_frame_cnt == 16'd1, "t1_frame_cnt", a_frame_cnt, 1);

        // 2: three words flushed exactly on timeout
        pl = '{8'h11, 8'h22, 8'h33};
        cs = build_frame(pl, fr);
        check(cs == 8'h9A, "t2_model_csum", cs, 8'h9A);
        enqueue(fr);
        @(negedge rclk);
        foreach (pl[k]) a_mem.push_back(pl[k]);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge rclk);
            n++;
            @(negedge rclk);
            #1;
            if (a_m_valid) break;
        end
        check(a_m_valid && a_m_sof, "t2_flush_sof", {a_m_valid, a_m_sof}, 2'b11);
        check(n == 65, "t2_flush_delay", n, 65);
        wait_drain(100, "t2_drain");
        check(a_frame_cnt == 16'd2, "t2_frame_cnt", a_frame_cnt, 2);

        // 3: 40 words under random backpressure -> 16 + 16, then an 8-word flush
        pl = {};
        for (int i = 0; i < 40; i++) pl.push_back(8'(8'h80 + i));
        begin
            logic [7:0] part[$];
            part = pl[0:15];  void'(build_frame(part, fr)); enqueue(fr);
            part = pl[16:31]; void'(build_frame(part, fr)); enqueue(fr);
            part = pl[32:39]; void'(build_frame(part, fr)); enqueue(fr);
        end
        @(negedge rclk);
        foreach (pl[k]) a_mem.push_back(pl[k]);
        for (n = 0; n < 3000; n++) begin
            @(negedge rclk);
            if (exp_q.size() <= 11) break;
            m_ready = 1'($urandom_range(0, 1));
        end
        check(n < 3000, "t3_two_frames", exp_q.size(), 11);
        m_ready = 1'b1;
        repeat (3) @(negedge rclk);
        #1;
        check(int'(a_ruse) + int'(a_ostage_v) == 8, "t3_left_in_fifo",
              int'(a_ruse) + int'(a_ostage_v), 8);
        check(a_m_valid == 1'b0, "t3_idle_before_flush", a_m_valid, 0);
        wait_drain(200, "t3_drain");

        // 4: backpressure held in HEAD, mid-BODY and CSUM
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(8'h30 + 3 * i));
        void'(build_frame(pl, fr));
        enqueue(fr);
        base = xfers;
        m_ready = 1'b0;
        @(negedge rclk);
        foreach (pl[k]) a_mem.push_back(pl[k]);
        for (n = 0; n < 20; n++) begin
            @(negedge rclk);
            if (a_m_valid) break;
        end
        check(a_m_sof == 1'b1, "t4_head_reached", a_m_sof, 1);
        hold10("t4_head");
        wait_xfers(base + 7, "t4_to_body");
        hold10("t4_body");
        wait_xfers(base + 18, "t4_to_csum");
        hold10("t4_csum");
        check(a_m_eof == 1'b1, "t4_csum_eof", a_m_eof, 1);
        m_ready = 1'b1;
        wait_drain(100, "t4_drain");

        // 5: reset mid-BODY abandons the frame; a clean frame follows
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(8'h50 + i));
        void'(build_frame(pl, fr));
        enqueue(fr);
        base = xfers;
        @(negedge rclk);
        foreach (pl[k]) a_mem.push_back(pl[k]);
        wait_xfers(base + 7, "t5_to_body");
        check(a_r_en == 1'b1, "t5_in_body", a_r_en, 1);
        rst_n = 1'b0;
        #1;
        check(a_r_en == 1'b0,    "t5_rst_r_en",  a_r_en, 0);
        check(a_m_valid == 1'b0, "t5_rst_valid", a_m_valid, 0);
        check(a_frame_cnt == 0,  "t5_rst_frame_cnt", a_frame_cnt, 0);
        repeat (2) @(negedge rclk);
        rst_n = 1'b1;
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(8'hC0 + i));
        void'(build_frame(pl, fr));
        enqueue(fr);
        @(negedge rclk);
        foreach (pl[k]) a_mem.push_back(pl[k]);
        wait_drain(100, "t5_drain");
        check(a_frame_cnt == 16'd1, "t5_frame_cnt", a_frame_cnt, 1);

        // 6: TIMEOUT=0 never flushes; reaching 16 words sends one full frame
        m_ready = 1'b1;
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(8'hE0 + i));
        void'(build_frame(pl, fr));
        @(negedge rclk);
        for (int i = 0; i < 5; i++) b_mem.push_back(pl[i]);
        vcnt = 0;
        repeat (200) begin
            @(negedge rclk);
            #2;
            if (b_m_valid) vcnt++;
        end
        check(vcnt == 0, "t6_no_flush", vcnt, 0);
        for (int i = 5; i < 16; i++) b_mem.push_back(pl[i]);
        got = {};
        for (int i = 0; i < 100; i++) begin
            @(negedge rclk);
            #2;
            if (b_m_valid) begin
                got.push_back({b_m_data, b_m_sof, b_m_eof});
                $display("b_xfer %0d data=0x%02h sof=%0b eof=%0b", got.size(), b_m_data, b_m_sof, b_m_eof);
                if (b_m_eof) break;
            end
        end
        check(got.size() == fr.size(), "t6_frame_size", got.size(), fr.size());
        for (int k = 0; k < fr.size(); k++) begin
            if (k < got.size()) check(got[k] == fr[k], "t6_word", got[k], fr[k]);
        end
        repeat (2) @(negedge rclk);
        check(b_frame_cnt == 16'd1, "t6_frame_cnt", b_frame_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
Read-domain consumer of the async FIFO. It drains the FIFO through the FIFO's read handshake (r_ok = valid, r_en = ready) and emits framed packets on a valid/ready stream: header, length, payload, checksum. It sends a full frame when FRAME_LEN words are available, and flushes a short frame after TIMEOUT idle cycles. It runs on the FIFO's read clock and shares its reset.

Parameters:
DSIZE, 8, data width; must equal the FIFO DSIZE.
ASIZE, 10, FIFO address width; sets the ruse width.
FRAME_LEN, 16, payload words per full frame; legal range 1..2^DSIZE-1 and 1..2^ASIZE.
TIMEOUT, 64, idle cycles before a partial flush; 0 disables flushing.
HEADER, 8'hA5, first word of every frame; zero-extended or truncated to DSIZE.

Ports:
rclk  in  1  clock (FIFO read clock)
rst_n  in  1  asynchronous reset, active low
rdata  in  DSIZE  FIFO read data
r_ok  in  1  FIFO data valid
ruse  in  ASIZE  FIFO used words (read domain)
r_en  out  1  FIFO read enable/ready; combinational
m_data  out  DSIZE  frame word
m_valid  out  1  frame word valid
m_ready  in  1  downstream ready
m_sof  out  1  high with the header word
m_eof  out  1  high with the checksum word
frame_cnt  out  16  completed frames; wraps at 2^16

Behaviour:
- Single clock rclk; reset asynchronous, active low (rst_n).
- Reset values:
  - state IDLE; len, remain, csum, timer all 0; frame_cnt 0.
  - Consequently r_en=0, m_valid=0, m_sof=0, m_eof=0, m_data=0.
- Handshake and availability:
  - A transfer occurs when valid & ready are high on a rclk edge, on both the FIFO side and the m_ side.
  - avail = ruse + r_ok, computed at ASIZE+1 bits. The word held in the FIFO output stage is not counted in ruse.
- States: IDLE -> HEAD -> LEN -> BODY -> CSUM -> IDLE.
- IDLE:
  - Drives r_en=0, m_valid=0, m_data=0.
  - timer clears when avail==0; otherwise increments, saturating at TIMEOUT.
  - If avail >= FRAME_LEN: len <= FRAME_LEN, go to HEAD.
  - Else if TIMEOUT != 0 and avail != 0 and timer == TIMEOUT-1: len <= avail[DSIZE-1:0], go to HEAD. Because avail < FRAME_LEN <= 2^DSIZE-1, this truncation is safe.
  - Full-frame start has priority over timeout.
- HEAD: m_valid=1, m_sof=1, m_data=HEADER. On m_ready, go to LEN.
- LEN: m_valid=1, m_data=len. On m_ready: remain <= len, csum <= 0, go to BODY.
- BODY:
  - Combinational pass-through: m_data=rdata, m_valid=r_ok, r_en=m_ready.
  - On r_ok & m_ready: csum <= csum + rdata (mod 2^DSIZE), remain <= remain-1.
  - If remain==1 at that transfer, go to CSUM.
  - No bubbles are inserted. The FIFO holds rdata stable while r_en=0, so m_data stays stable under backpressure.
- CSUM:
  - m_valid=1, m_eof=1, m_data = -csum (two's complement), so the sum of payload plus checksum is 0 mod 2^DSIZE.
  - On m_ready: frame_cnt++, timer <= 0, go to IDLE.
- Timing:
  - Latency from ruse reaching FRAME_LEN to the header valid: 1 cycle.
  - Overhead: 3 words per frame.
  - With m_ready held high, a full frame occupies FRAME_LEN+3 cycles, provided the FIFO keeps r_ok high.
- Boundary conditions:
  - r_en never asserts outside BODY, so no word is consumed between frames.
  - Every frame starts with avail >= len, so BODY cannot stall forever on r_ok. It may stall transiently.
  - m_ready low in any state holds that state, m_data and flags unchanged.
  - m_valid is never deasserted without a transfer, except in BODY, where m_valid follows the FIFO's r_ok.
  - ruse rising during a frame has no effect until IDLE.
  - rst_n asserted mid-frame: the frame is abandoned immediately, with no eof. The FIFO resets on the same rst_n, so data is discarded consistently.
  - Internal counter widths: remain and len are DSIZE bits; timer is clog2(TIMEOUT+1) bits, minimum 1.

Decomposition:
- Package fifo_frame_pkg:
  - state enum {IDLE, HEAD, LEN, BODY, CSUM}, 3 bits.
  - Default HEADER constant.
  - Checksum function (negated sum).
- Single module; no sub-module is needed.
- The timeout counter is simple enough to stay inline.

Test Plan:
1. Write 16 words 0x00..0x0F into the FIFO with m_ready=1 -> output A5(sof), 10, 00..0F, then 0x88(eof) (sum 0x78, negated 0x88); frame_cnt=1.
2. Write 3 words 0x11,0x22,0x33 and wait -> TIMEOUT cycles after first availability, output A5, 03, 11, 22, 33, 0x9A(eof). No frame may appear before the timeout.
3. Write 40 words with m_ready toggling in a random pattern -> exactly 2 full frames, every payload word exactly once and in order, checksums correct, 8 words left in the FIFO; avail=8 triggers a flush after TIMEOUT.
4. Hold m_ready=0 for 10 cycles in each of HEAD, mid-BODY and CSUM -> m_data, m_valid and flags are stable throughout; r_en=0; no FIFO word is lost.
5. Pulse rst_n low during BODY after 5 payload words -> r_en, m_valid and frame_cnt go to 0 immediately; after release and 16 new writes, a clean frame with sof follows.
6. Build with TIMEOUT=0 and write 5 words -> no output ever appears; write 11 more -> one full frame of 16.
